sipo_deframer: RTL

// Serial-to-parallel receiver downstream of the 4-bit PISO shifter.
// - Hunts for a start bit, shifts in WIDTH data bits MSB first, and presents the word on a
//   one-entry valid/ready output buffer.
// - Flags words lost to a full buffer (overrun).
//

---
 rtl/sipo_deframer_if.sv | 25 ++
 rtl/sipo_deframer.sv | 104 ++++++++++
 2 files changed

// File: rtl/sipo_deframer_if.sv
// Bundle of the serial input, output handshake and status signals around sipo_deframer.
// The master modport is the deframer side. The slave modport is the upstream/consumer side.
interface sipo_deframer_if #(
    parameter int WIDTH = 4
);
    logic             ser_in;
    logic             ser_en;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;
    logic             ovr_clr;
    logic             busy;
    logic             parity_err;

    modport master (
        input  ser_in, ser_en, out_ready, ovr_clr,
        output out_data, out_valid, overrun, busy, parity_err
    );

    modport slave (
        output ser_in, ser_en, out_ready, ovr_clr,
        input  out_data, out_valid, overrun, busy, parity_err
    );
endinterface

// File: rtl/sipo_deframer.sv
// Serial-to-parallel deframer: start-bit hunt, MSB-first shift, one-entry valid/ready buffer.
// Define PARITY_CHECK_EN to expect a trailing even-parity bit and report it on parity_err.
module sipo_deframer #(
    parameter int WIDTH = 4
) (
    input logic             clk,
    input logic             rst,
    sipo_deframer_if.master bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             overrun_q;
    logic             perr_q;
    logic             last_data;
    logic             commit;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    assign last_data = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

`ifdef PARITY_CHECK_EN
    assign commit    = bus.ser_en && (state == PARITY);
    assign word      = sh;
    assign word_perr = ^{sh, bus.ser_in};
`else
    assign commit    = bus.ser_en && last_data;
    assign word      = {sh[WIDTH-2:0], bus.ser_in};
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.ser_en) begin
            case (state)
                IDLE:    if (bus.ser_in) state_nxt = SHIFT;
`ifdef PARITY_CHECK_EN
                SHIFT:   if (last_data) state_nxt = PARITY;
`else
                SHIFT:   if (last_data) state_nxt = IDLE;
`endif
                PARITY:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            sh  <= '0;
        end else if (bus.ser_en) begin
            case (state)
                IDLE: if (bus.ser_in) cnt <= '0;
                SHIFT: begin
                    sh  <= {sh[WIDTH-2:0], bus.ser_in};
                    cnt <= last_data ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A commit lands if the buffer is empty or drained on the same edge; otherwise it is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (commit && (!valid_q || bus.out_ready)) begin
                data_q  <= word;
                valid_q <= 1'b1;
                perr_q  <= word_perr;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (commit && valid_q && !bus.out_ready) overrun_q <= 1'b1;
            else if (bus.ovr_clr)                    overrun_q <= 1'b0;
        end
    end

    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.parity_err = perr_q;
endmodule
